// File: rtl/inst_pkg.sv
// inst_pkg -- shared MIPS-subset encoding constants.
//
// Holds the instruction kind codes, the opcode and funct field values, and
// the encode helper.  The decoder side imports the same package so both ends
// agree on every field value.
package inst_pkg;

  // Instruction kinds presented on kind_i; 14 and 15 are illegal.
  typedef enum logic [3:0] {
    K_ADD  = 4'd0,
    K_SUB  = 4'd1,
    K_AND  = 4'd2,
    K_OR   = 4'd3,
    K_SLT  = 4'd4,
    K_MULT = 4'd5,
    K_ADDI = 4'd6,
    K_SLTI = 4'd7,
    K_LW   = 4'd8,
    K_SW   = 4'd9,
    K_BEQ  = 4'd10,
    K_BNE  = 4'd11,
    K_BGE  = 4'd12,
    K_BGT  = 4'd13
  } kind_e;

  localparam logic [3:0] KIND_LAST = 4'd13;

  // Opcodes, bits [31:26].
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BGE   = 6'b000001;
  localparam logic [5:0] OP_BGT   = 6'b000111;

  // R-type funct codes, bits [5:0].
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_MULT = 6'b011000;

  localparam logic [4:0] SHAMT_ZERO = 5'd0;

  function automatic logic kind_legal(input logic [3:0] kind);
    return (kind <= KIND_LAST);
  endfunction

  // R-type kinds ignore imm; I-type kinds ignore rd.  Illegal kinds yield 0,
  // but the caller never pushes them.
  function automatic logic [31:0] encode_inst(input logic [3:0]  kind,
                                              input logic [4:0]  rs,
                                              input logic [4:0]  rt,
                                              input logic [4:0]  rd,
                                              input logic [15:0] imm);
    logic [31:0] w;
    w = '0;
    case (kind_e'(kind))
      K_ADD:   w = {OP_RTYPE, rs, rt, rd, SHAMT_ZERO, FN_ADD};
      K_SUB:   w = {OP_RTYPE, rs, rt, rd, SHAMT_ZERO, FN_SUB};
      K_AND:   w = {OP_RTYPE, rs, rt, rd, SHAMT_ZERO, FN_AND};
      K_OR:    w = {OP_RTYPE, rs, rt, rd, SHAMT_ZERO, FN_OR};
      K_SLT:   w = {OP_RTYPE, rs, rt, rd, SHAMT_ZERO, FN_SLT};
      K_MULT:  w = {OP_RTYPE, rs, rt, rd, SHAMT_ZERO, FN_MULT};
      K_ADDI:  w = {OP_ADDI, rs, rt, imm};
      K_SLTI:  w = {OP_SLTI, rs, rt, imm};
      K_LW:    w = {OP_LW,   rs, rt, imm};
      K_SW:    w = {OP_SW,   rs, rt, imm};
      K_BEQ:   w = {OP_BEQ,  rs, rt, imm};
      K_BNE:   w = {OP_BNE,  rs, rt, imm};
      K_BGE:   w = {OP_BGE,  rs, rt, imm};
      K_BGT:   w = {OP_BGT,  rs, rt, imm};
      default: w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/inst_fifo.sv
// inst_fifo -- DEPTH-entry synchronous FIFO for encoded instruction words.
//
// Ports:
//   clk_i     clock
//   rst_i     synchronous active-low reset (pointers and count only)
//   push_i    write wdata_i at the tail (caller guarantees not full)
//   wdata_i   word to store
//   pop_i     drop the head entry (caller guarantees not empty)
//   rdata_o   head entry, combinational from storage
//   count_o   occupancy, 0..DEPTH
module inst_fifo
  import inst_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [DATA_W-1:0]          wdata_i,
  input  logic                       pop_i,
  output logic [DATA_W-1:0]          rdata_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [AW:0]       count_q;

  // Storage carries no reset; only the pointers and count decide validity.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem[wr_ptr_q] <= wdata_i;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata_o = mem[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/inst_encoder.sv
// inst_encoder -- encodes MIPS-subset instruction requests into 32-bit words
// and streams them out with consecutive byte addresses.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-low reset
//   in_valid_i/in_ready_o   request handshake
//   kind_i                  instruction kind (0-13 legal, 14-15 illegal)
//   rs_i, rt_i, rd_i        register fields
//   imm_i                   immediate / branch offset
//   out_valid_o/out_ready_i output handshake
//   inst_o, addr_o          encoded word and its byte address
//   err_o                   sticky: an illegal kind was accepted
//   count_o                 FIFO occupancy
module inst_encoder
  import inst_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [3:0]             kind_i,
  input  logic [4:0]             rs_i,
  input  logic [4:0]             rt_i,
  input  logic [4:0]             rd_i,
  input  logic [15:0]            imm_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [31:0]            inst_o,
  output logic [31:0]            addr_o,
  output logic                   err_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic        accept;
  logic        legal;
  logic        push;
  logic        pop;
  logic [31:0] inst_word;
  logic [AW:0] count;
  logic [31:0] addr_q;
  logic        err_q;

  // Ready depends only on occupancy: a full FIFO never takes a request even
  // if a pop happens in the same cycle.
  assign in_ready_o  = (count < FULL_CNT);
  assign out_valid_o = (count != '0);

  assign accept    = in_valid_i & in_ready_o;
  assign legal     = kind_legal(kind_i);
  assign push      = accept & legal;
  assign pop       = out_valid_o & out_ready_i;
  assign inst_word = encode_inst(kind_i, rs_i, rt_i, rd_i, imm_i);

  // Encoded words enter storage here; head appears one cycle after accept.
  inst_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (32)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .wdata_i (inst_word),
    .pop_i   (pop),
    .rdata_o (inst_o),
    .count_o (count)
  );

  // The address travels with the head rather than being stored per entry:
  // every pop moves to the next word, 4 bytes on, wrapping at 2^32.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      addr_q <= BASE_ADDR;
      err_q  <= 1'b0;
    end else begin
      if (pop) begin
        addr_q <= addr_q + 32'd4;
      end
      if (accept && !legal) begin
        err_q <= 1'b1;
      end
    end
  end

  assign addr_o  = addr_q;
  assign err_o   = err_q;
  assign count_o = count;

endmodule

// File: tb/tb_inst_encoder.sv
module tb_inst_encoder;

  logic        clk;
  logic        rst_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [3:0]  kind_i;
  logic [4:0]  rs_i, rt_i, rd_i;
  logic [15:0] imm_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] inst_o;
  logic [31:0] addr_o;
  logic        err_o;
  logic [2:0]  count_o;

  int total = 0;
  int bad   = 0;

  inst_encoder #(.DEPTH(4), .BASE_ADDR(32'h0000_0000)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .kind_i      (kind_i),
    .rs_i        (rs_i),
    .rt_i        (rt_i),
    .rd_i        (rd_i),
    .imm_i       (imm_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .inst_o      (inst_o),
    .addr_o      (addr_o),
    .err_o       (err_o),
    .count_o     (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // All tasks start and end 1 time unit after a rising edge.
  task automatic do_reset();
    rst_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
    kind_i = '0; rs_i = '0; rt_i = '0; rd_i = '0; imm_i = '0;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b1;
  endtask

  task automatic push1(input logic [3:0] k, input logic [4:0] s, input logic [4:0] t,
                       input logic [4:0] d, input logic [15:0] im);
    in_valid_i = 1'b1; kind_i = k; rs_i = s; rt_i = t; rd_i = d; imm_i = im;
    @(posedge clk); #1;
    in_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (count_o !== 3'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", count_o); end
    total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid_o); end
    total++; if (in_ready_o !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready_o); end
    total++; if (err_o !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", err_o); end
    total++; if (addr_o !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h exp=00000000", addr_o); end
  endtask

  task automatic test_add();
    do_reset();
    out_ready_i = 1'b1;
    push1(4'd0, 5'd1, 5'd2, 5'd3, 16'hABCD);
    total++; if (out_valid_o !== 1'b1) begin bad++; $display("FAIL add_valid got=%b exp=1", out_valid_o); end
    total++; if (inst_o !== 32'h00221820) begin bad++; $display("FAIL add_inst got=%h exp=00221820", inst_o); end
    total++; if (addr_o !== 32'h0) begin bad++; $display("FAIL add_addr got=%h exp=00000000", addr_o); end
    @(posedge clk); #1;
    total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL add_one_cycle got=%b exp=0", out_valid_o); end
    total++; if (addr_o !== 32'h4) begin bad++; $display("FAIL add_addr_adv got=%h exp=00000004", addr_o); end
  endtask

  task automatic test_lw_bge();
    do_reset();
    push1(4'd8,  5'd9, 5'd8, 5'd31, 16'h0004);
    push1(4'd12, 5'd1, 5'd2, 5'd0,  16'hFFFF);
    total++; if (count_o !== 3'd2) begin bad++; $display("FAIL lwbge_count got=%0d exp=2", count_o); end
    total++; if (inst_o !== 32'h8D280004) begin bad++; $display("FAIL lw_inst got=%h exp=8D280004", inst_o); end
    total++; if (addr_o !== 32'h0) begin bad++; $display("FAIL lw_addr got=%h exp=00000000", addr_o); end
    out_ready_i = 1'b1;
    @(posedge clk); #1;
    total++; if (inst_o !== 32'h0422FFFF) begin bad++; $display("FAIL bge_inst got=%h exp=0422FFFF", inst_o); end
    total++; if (addr_o !== 32'h4) begin bad++; $display("FAIL bge_addr got=%h exp=00000004", addr_o); end
    @(posedge clk); #1;
    total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL lwbge_drain got=%b exp=0", out_valid_o); end
    out_ready_i = 1'b0;
  endtask

  task automatic test_full_backpressure();
    logic [3:0]  k  [5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
    logic [4:0]  s  [5] = '{5'd4, 5'd7, 5'd1, 5'd2, 5'd3};
    logic [4:0]  t  [5] = '{5'd5, 5'd8, 5'd1, 5'd3, 5'd4};
    logic [4:0]  d  [5] = '{5'd6, 5'd9, 5'd1, 5'd4, 5'd0};
    logic [31:0] ex [5] = '{32'h00853022, 32'h00E84824, 32'h00210825, 32'h0043202A, 32'h00640018};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      total++;
      if (in_ready_o !== (i < 4)) begin bad++; $display("FAIL full_ready[%0d] got=%b exp=%b", i, in_ready_o, (i < 4)); end
      push1(k[i], s[i], t[i], d[i], 16'h1234);
    end
    total++; if (count_o !== 3'd4) begin bad++; $display("FAIL full_count got=%0d exp=4", count_o); end
    total++; if (in_ready_o !== 1'b0) begin bad++; $display("FAIL full_ready got=%b exp=0", in_ready_o); end
    repeat (2) @(posedge clk); #1;
    total++; if (inst_o !== ex[0]) begin bad++; $display("FAIL hold_inst got=%h exp=%h", inst_o, ex[0]); end
    total++; if (addr_o !== 32'h0) begin bad++; $display("FAIL hold_addr got=%h exp=00000000", addr_o); end
    out_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (inst_o !== ex[i]) begin bad++; $display("FAIL drain_inst[%0d] got=%h exp=%h", i, inst_o, ex[i]); end
      total++;
      if (addr_o !== 32'(i * 4)) begin bad++; $display("FAIL drain_addr[%0d] got=%h exp=%h", i, addr_o, 32'(i * 4)); end
      @(posedge clk); #1;
    end
    total++; if (count_o !== 3'd0) begin bad++; $display("FAIL drain_count got=%0d exp=0", count_o); end
    // Pointers have wrapped; next word lands at address 0x10.
    push1(4'd11, 5'd1, 5'd2, 5'd0, 16'h0003);
    total++; if (inst_o !== 32'h14220003) begin bad++; $display("FAIL wrap_inst got=%h exp=14220003", inst_o); end
    total++; if (addr_o !== 32'h10) begin bad++; $display("FAIL wrap_addr got=%h exp=00000010", addr_o); end
    @(posedge clk); #1;
    out_ready_i = 1'b0;
  endtask

  task automatic test_illegal();
    do_reset();
    push1(4'd14, 5'd1, 5'd2, 5'd3, 16'h0);
    total++; if (err_o !== 1'b1) begin bad++; $display("FAIL ill_err got=%b exp=1", err_o); end
    total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL ill_nopush got=%b exp=0", out_valid_o); end
    push1(4'd0, 5'd1, 5'd2, 5'd3, 16'h0);
    total++; if (inst_o !== 32'h00221820) begin bad++; $display("FAIL ill_add_inst got=%h exp=00221820", inst_o); end
    total++; if (count_o !== 3'd1) begin bad++; $display("FAIL ill_add_count got=%0d exp=1", count_o); end
    repeat (3) @(posedge clk); #1;
    total++; if (err_o !== 1'b1) begin bad++; $display("FAIL ill_sticky got=%b exp=1", err_o); end
  endtask

  task automatic test_other_kinds();
    logic [3:0]  k  [5] = '{4'd6, 4'd7, 4'd9, 4'd10, 4'd13};
    logic [31:0] ex [5] = '{32'h20010005, 32'h28010005, 32'hAFBF0008, 32'h10220003, 32'h1C22FFFE};
    logic [4:0]  s  [5] = '{5'd0, 5'd0, 5'd29, 5'd1, 5'd1};
    logic [4:0]  t  [5] = '{5'd1, 5'd1, 5'd31, 5'd2, 5'd2};
    logic [15:0] im [5] = '{16'h0005, 16'h0005, 16'h0008, 16'h0003, 16'hFFFE};
    do_reset();
    out_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push1(k[i], s[i], t[i], 5'd17, im[i]);
      total++;
      if (inst_o !== ex[i]) begin bad++; $display("FAIL itype_inst[%0d] got=%h exp=%h", i, inst_o, ex[i]); end
    end
    @(posedge clk); #1;
    out_ready_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    push1(4'd6, 5'd0,  5'd1,  5'd0, 16'h0005);
    push1(4'd9, 5'd29, 5'd31, 5'd0, 16'h0008);
    total++; if (count_o !== 3'd2) begin bad++; $display("FAIL b2b_pre_count got=%0d exp=2", count_o); end
    out_ready_i = 1'b1;
    push1(4'd10, 5'd1, 5'd2, 5'd0, 16'h0003);
    out_ready_i = 1'b0;
    total++; if (count_o !== 3'd2) begin bad++; $display("FAIL b2b_count got=%0d exp=2", count_o); end
    total++; if (inst_o !== 32'hAFBF0008) begin bad++; $display("FAIL b2b_head got=%h exp=AFBF0008", inst_o); end
    total++; if (addr_o !== 32'h4) begin bad++; $display("FAIL b2b_addr got=%h exp=00000004", addr_o); end
    out_ready_i = 1'b1;
    @(posedge clk); #1;
    total++; if (inst_o !== 32'h10220003) begin bad++; $display("FAIL b2b_tail got=%h exp=10220003", inst_o); end
    total++; if (addr_o !== 32'h8) begin bad++; $display("FAIL b2b_tail_addr got=%h exp=00000008", addr_o); end
    @(posedge clk); #1;
    out_ready_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    push1(4'd0, 5'd1, 5'd2, 5'd3, 16'h0);
    push1(4'd1, 5'd4, 5'd5, 5'd6, 16'h0);
    push1(4'd2, 5'd7, 5'd8, 5'd9, 16'h0);
    total++; if (count_o !== 3'd3) begin bad++; $display("FAIL mid_pre_count got=%0d exp=3", count_o); end
    rst_i = 1'b0; out_ready_i = 1'b1;
    in_valid_i = 1'b1; kind_i = 4'd15; rs_i = 5'd1;
    @(posedge clk); #1;
    in_valid_i = 1'b0; out_ready_i = 1'b0; rst_i = 1'b1;
    total++; if (count_o !== 3'd0) begin bad++; $display("FAIL mid_count got=%0d exp=0", count_o); end
    total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b exp=0", out_valid_o); end
    total++; if (addr_o !== 32'h0) begin bad++; $display("FAIL mid_addr got=%h exp=00000000", addr_o); end
    total++; if (err_o !== 1'b0) begin bad++; $display("FAIL mid_err got=%b exp=0", err_o); end
    @(posedge clk); #1;
    total++; if (in_ready_o !== 1'b1) begin bad++; $display("FAIL mid_ready got=%b exp=1", in_ready_o); end
  endtask

  initial begin
    rst_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
    kind_i = '0; rs_i = '0; rt_i = '0; rd_i = '0; imm_i = '0;
    @(posedge clk); #1;
    test_reset();
    test_add();
    test_lw_bge();
    test_full_backpressure();
    test_illegal();
    test_other_kinds();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
